// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: flush FSM state encoding and jump kinds.
// Imported by flush_ctrl and by the jump unit that drives it.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_REFILL = 2'd3
    } ctrl_state_t;

    typedef enum logic [1:0] {
        JT_JAL    = 2'd0,
        JT_JALR   = 2'd1,
        JT_BRANCH = 2'd2
    } jump_type_t;

    localparam int REFILL_CNT_W = 3;
    localparam int STAT_W       = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for pipeline statistics.
// Ports: clock, reset (sync, active-high), inc, count (holds at all-ones).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/flush_ctrl.sv
// Pipeline flush/stall controller: turns jump-unit redirects and hazards
// into pc_sel/pc_next, per-stage stall/flush strobes and pipe_valid.
// Ports: clock, reset (sync, active-high); redirect, redirect_pc,
//   redirect_is_branch, halt_req, mem_wait in; pc_sel, pc_next,
//   stall_if/id, flush_if/id/ex, pipe_valid, redirect_cnt, stall_cnt out.
// Build macro FLUSH_CTRL_STATS_EN enables the statistics counters;
//   otherwise redirect_cnt and stall_cnt are tied to 0.
module flush_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PC_W          = 32,
    parameter int REFILL_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              redirect_is_branch,
    input  logic              halt_req,
    input  logic              mem_wait,
    output logic              pc_sel,
    output logic [PC_W-1:0]   pc_next,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_if,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              pipe_valid,
    output logic [STAT_W-1:0] redirect_cnt,
    output logic [STAT_W-1:0] stall_cnt
);

    localparam logic [REFILL_CNT_W-1:0] REFILL_INIT =
        REFILL_CNT_W'(REFILL_CYCLES - 1);

    ctrl_state_t             state_q, state_d;
    logic [PC_W-1:0]         pc_q, pc_d;
    logic                    br_q, br_d;
    logic [REFILL_CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
        end
    end

    // A redirect wins in every state: from FLUSH it simply re-enters FLUSH
    // with the new target, so no separate pending-redirect buffer is needed.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        if (redirect) begin
            state_d = ST_FLUSH;
            pc_d    = redirect_pc;
            br_d    = redirect_is_branch;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (halt_req || mem_wait) state_d = ST_STALL;
                end
                ST_STALL: begin
                    if (!halt_req && !mem_wait) state_d = ST_RUN;
                end
                ST_FLUSH: begin
                    state_d = ST_REFILL;
                    cnt_d   = REFILL_INIT;
                end
                ST_REFILL: begin
                    if (!mem_wait) begin
                        if (cnt_q == '0) state_d = ST_RUN;
                        else             cnt_d   = cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        pc_sel     = 1'b0;
        flush_if   = 1'b0;
        flush_id   = 1'b0;
        flush_ex   = 1'b0;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        pipe_valid = 1'b0;
        unique case (1'b1)
            (state_q == ST_RUN): pipe_valid = 1'b1;
            (state_q == ST_STALL): begin
                stall_if = 1'b1;
                stall_id = 1'b1;
            end
            (state_q == ST_FLUSH): begin
                pc_sel   = 1'b1;
                flush_if = 1'b1;
                // Late branches already let younger ops reach ID/EX.
                flush_id = br_q;
                flush_ex = br_q;
            end
            default: ;
        endcase
    end

    assign pc_next = pc_q;

`ifdef FLUSH_CTRL_STATS_EN
    // Every accepted redirect enters FLUSH on the next edge.
    logic stall_inc;
    assign stall_inc = (state_q == ST_STALL);

    sat_counter #(.W(STAT_W)) u_redirect_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (redirect),
        .count (redirect_cnt)
    );

    sat_counter #(.W(STAT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );
`else
    assign redirect_cnt = '0;
    assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_flush_ctrl.sv
// Directed self-checking bench for flush_ctrl (PC_W=32, REFILL_CYCLES=2).
// Counter expectations follow FLUSH_CTRL_STATS_EN.
module tb_flush_ctrl;

`ifdef FLUSH_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        redirect_is_branch;
    logic        halt_req;
    logic        mem_wait;
    logic        pc_sel;
    logic [31:0] pc_next;
    logic        stall_if, stall_id;
    logic        flush_if, flush_id, flush_ex;
    logic        pipe_valid;
    logic [31:0] redirect_cnt, stall_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    flush_ctrl #(.PC_W(32), .REFILL_CYCLES(2)) dut (
        .clock              (clock),
        .reset              (reset),
        .redirect           (redirect),
        .redirect_pc        (redirect_pc),
        .redirect_is_branch (redirect_is_branch),
        .halt_req           (halt_req),
        .mem_wait           (mem_wait),
        .pc_sel             (pc_sel),
        .pc_next            (pc_next),
        .stall_if           (stall_if),
        .stall_id           (stall_id),
        .flush_if           (flush_if),
        .flush_id           (flush_id),
        .flush_ex           (flush_ex),
        .pipe_valid         (pipe_valid),
        .redirect_cnt       (redirect_cnt),
        .stall_cnt          (stall_cnt)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected order: pc_sel flush_if flush_id flush_ex stall_if stall_id pipe_valid
    task automatic chk_out(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, pc_sel, flush_if, flush_id, flush_ex,
                  stall_if, stall_id, pipe_valid}, {25'd0, exp});
    endtask

    function automatic logic [31:0] st(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    task automatic do_redirect(input logic [31:0] pc, input logic br);
        redirect           = 1'b1;
        redirect_pc        = pc;
        redirect_is_branch = br;
        tick();
        redirect           = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        redirect           = 1'b0;
        redirect_pc        = '0;
        redirect_is_branch = 1'b0;
        halt_req           = 1'b0;
        mem_wait           = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk_out("reset_outs", 7'b0000001);
        chk("reset_pc", pc_next, 32'h0);
        chk("reset_rcnt", redirect_cnt, 32'h0);
        chk("reset_scnt", stall_cnt, 32'h0);

        // Branch redirect to 0x40
        do_redirect(32'h40, 1'b1);
        chk_out("br_flush", 7'b1111000);
        chk("br_pc", pc_next, 32'h40);
        chk("br_rcnt", redirect_cnt, st(1));
        tick();
        chk_out("br_refill1", 7'b0000000);
        tick();
        chk_out("br_refill2", 7'b0000000);
        tick();
        chk_out("br_run", 7'b0000001);

        // JAL redirect to 0x100
        do_redirect(32'h100, 1'b0);
        chk_out("jal_flush", 7'b1100000);
        chk("jal_pc", pc_next, 32'h100);
        tick();
        tick();
        tick();
        chk_out("jal_run", 7'b0000001);
        chk("jal_rcnt", redirect_cnt, st(2));

        // halt_req for 3 cycles
        halt_req = 1'b1;
        tick();
        chk_out("halt_s1", 7'b0000110);
        tick();
        chk_out("halt_s2", 7'b0000110);
        tick();
        chk_out("halt_s3", 7'b0000110);
        halt_req = 1'b0;
        tick();
        chk_out("halt_run", 7'b0000001);
        chk("halt_scnt", stall_cnt, st(3));

        // Second redirect during REFILL restarts the sequence
        do_redirect(32'h80, 1'b1);
        chk_out("rr_flush1", 7'b1111000);
        tick();
        chk_out("rr_refill", 7'b0000000);
        do_redirect(32'h200, 1'b0);
        chk_out("rr_flush2", 7'b1100000);
        chk("rr_pc", pc_next, 32'h200);
        tick();
        chk_out("rr_refill_a", 7'b0000000);
        tick();
        chk_out("rr_refill_b", 7'b0000000);
        tick();
        chk_out("rr_run", 7'b0000001);
        chk("rr_rcnt", redirect_cnt, st(4));

        // mem_wait stretches REFILL
        do_redirect(32'h300, 1'b1);
        mem_wait = 1'b1;
        tick();
        chk_out("mw_refill1", 7'b0000000);
        tick();
        chk_out("mw_hold1", 7'b0000000);
        tick();
        chk_out("mw_hold2", 7'b0000000);
        mem_wait = 1'b0;
        tick();
        chk_out("mw_last", 7'b0000000);
        tick();
        chk_out("mw_run", 7'b0000001);

        // Redirect during FLUSH gives a back-to-back FLUSH
        do_redirect(32'h400, 1'b1);
        chk_out("ff_flush1", 7'b1111000);
        do_redirect(32'h500, 1'b0);
        chk_out("ff_flush2", 7'b1100000);
        chk("ff_pc", pc_next, 32'h500);
        tick();
        tick();
        tick();
        chk_out("ff_run", 7'b0000001);
        chk("ff_rcnt", redirect_cnt, st(7));

        // halt_req ignored through FLUSH and REFILL
        do_redirect(32'h600, 1'b0);
        halt_req = 1'b1;
        tick();
        chk_out("hi_refill1", 7'b0000000);
        tick();
        chk_out("hi_refill2", 7'b0000000);
        tick();
        chk_out("hi_run", 7'b0000001);
        halt_req = 1'b0;

        // mem_wait in RUN stalls
        mem_wait = 1'b1;
        tick();
        chk_out("mwr_stall", 7'b0000110);
        mem_wait = 1'b0;
        tick();
        chk_out("mwr_run", 7'b0000001);
        chk("mwr_scnt", stall_cnt, st(4));

        // Redirect beats halt_req while in STALL
        halt_req = 1'b1;
        tick();
        chk_out("rs_stall", 7'b0000110);
        do_redirect(32'h700, 1'b1);
        halt_req = 1'b0;
        chk_out("rs_flush", 7'b1111000);
        chk("rs_pc", pc_next, 32'h700);
        chk("rs_rcnt", redirect_cnt, st(9));
        chk("rs_scnt", stall_cnt, st(5));

        // Reset during FLUSH abandons it
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_out("rf_outs", 7'b0000001);
        chk("rf_pc", pc_next, 32'h0);
        chk("rf_rcnt", redirect_cnt, 32'h0);
        chk("rf_scnt", stall_cnt, 32'h0);
        tick();
        chk_out("rf_stay", 7'b0000001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
